// File: rtl/line_window_if.sv
// Port bundle between the HDMI RX strobes, the 5x5 window datapath and the line sequencer.
// The sequencer takes the slave side; the source/observer takes the master side.
interface line_window_if #(
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 11,
  parameter int KSIZE  = 5
);
  logic                     rx_dv;
  logic                     rx_hs;
  logic                     rx_vs;
  logic [ADDR_W-1:0]        wr_addr;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     line_we;
  logic [ADDR_W-1:0]        col_cnt;
  logic [ROW_W-1:0]         row_cnt;
  logic [KSIZE*KSIZE-1:0]   tap_mask;
  logic                     win_full;
  logic                     frame_start;
  logic [ADDR_W-1:0]        line_len;
  logic                     err_len;
  logic                     err_ovf;

  modport master (
    output rx_dv, rx_hs, rx_vs,
    input  wr_addr, rd_addr, line_we, col_cnt, row_cnt, tap_mask,
           win_full, frame_start, line_len, err_len, err_ovf
  );

  modport slave (
    input  rx_dv, rx_hs, rx_vs,
    output wr_addr, rd_addr, line_we, col_cnt, row_cnt, tap_mask,
           win_full, frame_start, line_len, err_len, err_ovf
  );
endinterface

// File: rtl/line_window_ctrl.sv
// Frame/line/pixel sequencer for the 5x5 line-buffer window: BRAM addressing,
// per-tap in-frame mask, line-length measurement and timing fault flags.
module line_window_ctrl #(
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 11,
  parameter int KSIZE  = 5
) (
  input  logic          clk,
  input  logic          rst,
  line_window_if.slave  bus
);
  localparam int TAPS = KSIZE * KSIZE;
  localparam logic [ADDR_W-1:0] COL_MAX = '1;
  localparam logic [ROW_W-1:0]  ROW_MAX = '1;

  typedef enum logic [1:0] {IDLE, FWAIT, ACTIVE, HBLANK} state_t;

  state_t              r_state, w_next;
  logic                r_vs_d;
  logic [ADDR_W-1:0]   r_col;
  logic [ROW_W-1:0]    r_row;
  logic [TAPS-1:0]     r_tap;
  logic                r_full, r_fs;
  logic [ADDR_W-1:0]   r_len;
  logic                r_err_len, r_err_ovf;

  logic                w_vs_rise, w_accept, w_first, w_line_end, w_ovf;
  logic [ADDR_W-1:0]   w_col, w_len;
  logic [ROW_W-1:0]    w_row;
  logic [TAPS-1:0]     w_mask;

  // Tap (jj,ii) is real when the window reaches back jj lines and ii pixels inside the frame.
  function automatic logic [TAPS-1:0] f_mask(input logic [ROW_W-1:0] row,
                                             input logic [ADDR_W-1:0] col);
    logic [TAPS-1:0] m;
    m = '0;
    for (int jj = 0; jj < KSIZE; jj++)
      for (int ii = 0; ii < KSIZE; ii++)
        m[KSIZE*jj+ii] = (row >= ROW_W'(jj)) && (col >= ADDR_W'(ii));
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_vs_rise  = bus.rx_vs & ~r_vs_d;
    w_next     = r_state;
    w_accept   = 1'b0;
    w_first    = 1'b0;
    w_line_end = 1'b0;
    if (w_vs_rise) begin
      // A frame restart overrides whatever line was in progress.
      w_next   = bus.rx_dv ? ACTIVE : FWAIT;
      w_accept = bus.rx_dv;
      w_first  = bus.rx_dv;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        FWAIT:   if (bus.rx_dv) begin
                   w_next   = ACTIVE;
                   w_accept = 1'b1;
                   w_first  = 1'b1;
                 end
        ACTIVE:  if (bus.rx_dv) begin
                   w_accept = 1'b1;
                 end else begin
                   w_next     = HBLANK;
                   w_line_end = 1'b1;
                 end
        HBLANK:  if (bus.rx_dv) begin
                   w_next   = ACTIVE;
                   w_accept = 1'b1;
                 end
        default: w_next = IDLE;
      endcase
    end
  end

  // Position of the pixel on rx_* this cycle, derived from the last accepted pixel.
  always_comb begin
    w_col = '0;
    w_row = '0;
    w_ovf = 1'b0;
    if (!w_first) begin
      if (r_state == ACTIVE) begin
        w_row = r_row;
        if (r_col == COL_MAX) begin
          w_col = COL_MAX;
          w_ovf = 1'b1;
        end else begin
          w_col = r_col + 1'b1;
        end
      end else if (r_state == HBLANK) begin
        w_row = (r_row == ROW_MAX) ? ROW_MAX : r_row + 1'b1;
      end
    end
    w_mask = f_mask(w_row, w_col);
    w_len  = r_col + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs_d    <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_tap     <= '0;
      r_full    <= 1'b0;
      r_fs      <= 1'b0;
      r_len     <= '0;
      r_err_len <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_vs_d <= bus.rx_vs;
      r_fs   <= w_first;
      r_tap  <= w_accept ? w_mask : '0;
      r_full <= w_accept & (&w_mask);
      if (w_accept) begin
        r_col <= w_col;
        r_row <= w_row;
      end else if (w_vs_rise) begin
        r_col <= '0;
        r_row <= '0;
      end
      if (w_vs_rise)
        r_err_len <= 1'b0;
      else if (w_line_end && (r_row != '0) && (w_len != r_len))
        r_err_len <= 1'b1;
      if (w_line_end)
        r_len <= w_len;
      if (w_accept && w_ovf)
        r_err_ovf <= 1'b1;
    end
  end

  assign bus.wr_addr     = w_col;
  assign bus.rd_addr     = w_accept ? w_col + 1'b1 : '0;
  assign bus.line_we     = w_accept;
  assign bus.col_cnt     = r_col;
  assign bus.row_cnt     = r_row;
  assign bus.tap_mask    = r_tap;
  assign bus.win_full    = r_full;
  assign bus.frame_start = r_fs;
  assign bus.line_len    = r_len;
  assign bus.err_len     = r_err_len;
  assign bus.err_ovf     = r_err_ovf;
endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: pixel-position reference model checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_line_window_ctrl;
  localparam int AW   = 11;
  localparam int RW   = 11;
  localparam int CMAX = 2047;
  localparam int RMAX = 2047;

  logic clk = 1'b0;
  logic rst = 1'b0;

  line_window_if #(.ADDR_W(AW), .ROW_W(RW), .KSIZE(5)) bus ();

  line_window_ctrl #(.ADDR_W(AW), .ROW_W(RW), .KSIZE(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what has been seen so far in terms of frames, lines and pixels.
  bit  m_armed, m_started, m_in_line, m_vs_d, m_err_len, m_err_ovf;
  int  m_row, m_cnt, m_len;
  int  e_row, e_col;
  bit  e_full, e_fs;
  logic [24:0] e_mask;

  bit  mv_acc, mv_fs, mv_vsr;
  int  mv_r, mv_c, mv_len;
  bit  cv_acc, cv_fs;
  int  cv_r, cv_c;

  int  pr, pc;
  bit  pv;
  int  wf_total, wf_row4, wf_first_r, wf_first_c;
  bit  wf_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [24:0] exp_mask(input int r, input int c);
    logic [24:0] m;
    m = '0;
    for (int jj = 0; jj < 5; jj++)
      for (int ii = 0; ii < 5; ii++)
        if (r >= jj && c >= ii) m[5*jj+ii] = 1'b1;
    return m;
  endfunction

  // Where the pixel currently on the inputs lands in the frame (if it is taken at all).
  task automatic m_eval(output bit acc, output bit fs, output int r, output int c);
    bit vsr;
    vsr = bus.rx_vs && !m_vs_d;
    acc = rst && bus.rx_dv && (m_armed || vsr);
    fs  = acc && (vsr || !m_started);
    if (fs) begin
      r = 0;
      c = 0;
    end else if (m_in_line) begin
      r = m_row;
      c = (m_cnt > CMAX) ? CMAX : m_cnt;
    end else begin
      r = (m_row >= RMAX) ? RMAX : m_row + 1;
      c = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_armed = 0; m_started = 0; m_in_line = 0; m_vs_d = 0;
      m_err_len = 0; m_err_ovf = 0;
      m_row = 0; m_cnt = 0; m_len = 0;
      e_row = 0; e_col = 0; e_full = 0; e_fs = 0; e_mask = '0;
    end else begin
      m_eval(mv_acc, mv_fs, mv_r, mv_c);
      mv_vsr = bus.rx_vs && !m_vs_d;
      if (mv_vsr) begin
        m_started = 0;
        m_err_len = 0;
        m_row = 0;
        e_row = 0;
        e_col = 0;
      end else if (m_in_line && !bus.rx_dv) begin
        mv_len = ((m_cnt > CMAX + 1) ? CMAX + 1 : m_cnt) % (CMAX + 1);
        if (m_row > 0 && mv_len != m_len) m_err_len = 1;
        m_len = mv_len;
      end
      if (mv_acc) begin
        if (m_in_line && !mv_vsr && m_cnt > CMAX) m_err_ovf = 1;
        m_cnt = (mv_vsr || !m_in_line) ? 1 : m_cnt + 1;
        m_row = mv_r;
        e_row = mv_r;
        e_col = mv_c;
        m_started = 1;
      end
      m_in_line = mv_acc;
      e_mask = mv_acc ? exp_mask(mv_r, mv_c) : '0;
      e_full = mv_acc && mv_r >= 4 && mv_c >= 4;
      e_fs   = mv_fs;
      if (mv_vsr) m_armed = 1;
      m_vs_d = bus.rx_vs;
    end
  end

  // Every cycle: combinational addressing for the inputs now applied, registered outputs
  // for the pixel of the previous cycle.
  initial forever begin
    @(negedge clk);
    #2;
    m_eval(cv_acc, cv_fs, cv_r, cv_c);
    chk("line_we", 32'(bus.line_we), 32'(cv_acc));
    if (cv_acc) begin
      chk("wr_addr", 32'(bus.wr_addr), cv_c);
      chk("rd_addr", 32'(bus.rd_addr), (cv_c + 1) % (CMAX + 1));
    end else begin
      chk("rd_addr_idle", 32'(bus.rd_addr), 0);
    end
    chk("col_cnt",     32'(bus.col_cnt),     e_col);
    chk("row_cnt",     32'(bus.row_cnt),     e_row);
    chk("tap_mask",    32'(bus.tap_mask),    32'(e_mask));
    chk("win_full",    32'(bus.win_full),    32'(e_full));
    chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
    chk("line_len",    32'(bus.line_len),    m_len);
    chk("err_len",     32'(bus.err_len),     32'(m_err_len));
    chk("err_ovf",     32'(bus.err_ovf),     32'(m_err_ovf));
  end

  task automatic cyc(input bit dv, input bit vs);
    @(negedge clk);
    bus.rx_dv = dv;
    bus.rx_vs = vs;
  endtask

  task automatic vs_pulse();
    cyc(0, 1); cyc(0, 1); cyc(0, 0); cyc(0, 0);
  endtask

  task automatic line(input int n, input int hb);
    for (int i = 0; i < n; i++) cyc(1, 0);
    for (int i = 0; i < hb; i++) cyc(0, 0);
  endtask

  // Directed checks on the registered outputs of the pixel driven one cycle earlier.
  task automatic post();
    #3;
    if (pv && pr == 0 && pc == 0) chk("t3_mask_r0c0", 32'(bus.tap_mask), 32'h0000001);
    if (pv && pr == 0 && pc == 4) chk("t3_mask_r0c4", 32'(bus.tap_mask), 32'h000001F);
    if (pv && pr == 0 && pc == 9) chk("t3_mask_r0c9", 32'(bus.tap_mask), 32'h000001F);
    if (pv && pr == 2 && pc == 1) chk("t3_mask_r2c1", 32'(bus.tap_mask), 32'h0000C63);
    if (pv && pr == 4 && pc == 3) chk("t2_wf_r4c3",   32'(bus.win_full), 0);
    if (pv && pr == 7 && pc == 15) chk("t2_mask_full", 32'(bus.tap_mask), 32'h1FFFFFF);
    if (bus.win_full === 1'b1) begin
      wf_total++;
      if (pr == 4) wf_row4++;
      if (!wf_seen) begin
        wf_seen    = 1;
        wf_first_r = pr;
        wf_first_c = pc;
      end
    end
  endtask

  initial begin
    bus.rx_dv = 1'b0;
    bus.rx_vs = 1'b0;
    bus.rx_hs = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_tap_mask", 32'(bus.tap_mask), 0);
    chk("rst_line_len", 32'(bus.line_len), 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: pixels before any vsync are ignored; reset in the middle of a line
    for (int i = 0; i < 4; i++) cyc(1, 0);
    #3 chk("t1_idle_we", 32'(bus.line_we), 0);
    cyc(0, 0);
    vs_pulse();
    for (int i = 0; i < 38; i++) cyc(1, 0);
    #3 chk("t1_wr_c37", 32'(bus.wr_addr), 37);
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("t1_rst_col", 32'(bus.col_cnt), 0);
    chk("t1_rst_tap", 32'(bus.tap_mask), 0);
    chk("t1_rst_we",  32'(bus.line_we), 0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1, 0);
    #3 chk("t1_ignored_we", 32'(bus.line_we), 0);
    cyc(0, 0); cyc(0, 1); cyc(0, 0);
    cyc(1, 0);
    #3;
    chk("t1_first_wr", 32'(bus.wr_addr), 0);
    chk("t1_first_rd", 32'(bus.rd_addr), 1);
    cyc(1, 0);
    #3 chk("t1_frame_start", 32'(bus.frame_start), 1);
    cyc(1, 0);
    #3 chk("t1_fs_single", 32'(bus.frame_start), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0);

    // 2 and 3: 8 lines of 16 px with 4-cycle blanking
    vs_pulse();
    pv = 0; wf_total = 0; wf_row4 = 0; wf_seen = 0; wf_first_r = -1; wf_first_c = -1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        cyc(1, 0);
        post();
        pr = r; pc = c; pv = 1;
      end
      for (int h = 0; h < 4; h++) begin
        cyc(0, 0);
        post();
        pv = 0;
      end
      chk("t2_line_len", 32'(bus.line_len), 16);
      chk("t2_err_len",  32'(bus.err_len), 0);
    end
    chk("t2_wf_first_row", wf_first_r, 4);
    chk("t2_wf_first_col", wf_first_c, 4);
    chk("t2_wf_row4",      wf_row4, 12);
    chk("t2_wf_total",     wf_total, 48);

    // 4: short line 3 raises err_len until the next vsync
    vs_pulse();
    line(16, 4); line(16, 4); line(16, 4);
    chk("t4_err_before", 32'(bus.err_len), 0);
    line(15, 4);
    chk("t4_err_len", 32'(bus.err_len), 1);
    chk("t4_len15",   32'(bus.line_len), 15);
    line(16, 4);
    chk("t4_err_sticky", 32'(bus.err_len), 1);
    chk("t4_len16",      32'(bus.line_len), 16);
    cyc(0, 1);
    cyc(0, 0);
    #3;
    chk("t4_err_cleared", 32'(bus.err_len), 0);
    chk("t4_row_cleared", 32'(bus.row_cnt), 0);
    cyc(0, 0);

    // 5: vsync rising together with an active pixel mid-line
    vs_pulse();
    line(16, 4);
    for (int i = 0; i < 7; i++) cyc(1, 0);
    cyc(1, 1);
    #3;
    chk("t5_wr_addr", 32'(bus.wr_addr), 0);
    chk("t5_rd_addr", 32'(bus.rd_addr), 1);
    cyc(1, 1);
    #3;
    chk("t5_frame_start", 32'(bus.frame_start), 1);
    chk("t5_row",         32'(bus.row_cnt), 0);
    chk("t5_col",         32'(bus.col_cnt), 0);
    chk("t5_tap",         32'(bus.tap_mask), 32'h0000001);
    cyc(1, 0);
    #3;
    chk("t5_col_next", 32'(bus.col_cnt), 1);
    chk("t5_fs_low",   32'(bus.frame_start), 0);
    for (int i = 0; i < 5; i++) cyc(1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0);

    // 6: over-long line saturates the column counter
    vs_pulse();
    for (int i = 0; i < 2051; i++) cyc(1, 0);
    #3;
    chk("t6_wr_hold",  32'(bus.wr_addr), 2047);
    chk("t6_we",       32'(bus.line_we), 1);
    chk("t6_col_hold", 32'(bus.col_cnt), 2047);
    chk("t6_err_ovf",  32'(bus.err_ovf), 1);
    cyc(0, 0);
    #3 chk("t6_col_after", 32'(bus.col_cnt), 2047);
    for (int i = 0; i < 3; i++) cyc(0, 0);
    vs_pulse();
    #3 chk("t6_ovf_keep_vs", 32'(bus.err_ovf), 1);
    line(8, 4);
    chk("t6_ovf_keep_line", 32'(bus.err_ovf), 1);
    chk("t6_len8",          32'(bus.line_len), 8);
    @(negedge clk);
    rst = 1'b0;
    #3 chk("t6_ovf_rst", 32'(bus.err_ovf), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
